serial_deserializer: RTL
========================

Name: serial_deserializer

Overview:
Receive side of the team's serial shift link. Collects a bit stream (one bit per strobe, MSB-first or LSB-first) into N-bit words. Presents each word on a valid/ready output with a one-word holding register. Sits downstream of the parallel-load/serial-shift register and is the partner that reconstructs its words; includes frame resync and sticky overrun detection.

Parameters:
N, 8, word width in bits (N >= 2)
CW, $clog2(N), width of bit_count (derived, not overridden)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
ser_in  input  1  serial data bit
ser_valid  input  1  ser_in is sampled on this edge when high
msb_first  input  1  1: first bit received lands in bit N-1 (shift left); 0: first bit lands in bit 0 (shift right)
sync  input  1  frame resync; discards any partial word
clr_overrun  input  1  clears sticky overrun
data_out  output  N  assembled word
data_valid  output  1  data_out holds an unconsumed word
data_ready  input  1  consumer accepts data_out when data_valid & data_ready
overrun  output  1  sticky: a completed word was dropped
busy  output  1  high while a partial word is in progress (state SHIFT)
bit_count  output  CW  bits collected in current word (0..N-1)

Behaviour:
- Reset (rst_n low, async): state IDLE, shift reg 0, bit_count 0, data_out 0, data_valid 0, overrun 0, busy 0. Reset mid-word drops the partial word and any held word.
- FSM: IDLE (no bits held) and SHIFT (1..N-1 bits held). busy = (state == SHIFT).
- Direction is latched from msb_first when a word's first bit is accepted. It stays fixed until the word completes or is discarded. msb_first changes mid-word are ignored.
- Bit accept (ser_valid=1):
  - direction left: sh <= {sh[N-2:0], ser_in}
  - direction right: sh <= {ser_in, sh[N-1:1]}
  - bit_count increments.
  - IDLE -> SHIFT on the first bit.
- Word completion: the Nth accepted bit. The fully shifted value goes directly to data_out on that same edge, and data_valid is set. bit_count -> 0 and state -> IDLE on the same edge. Latency: data_valid is high in the cycle after the Nth bit's sampling edge.
- Output handshake: a transfer occurs on an edge with data_valid & data_ready. data_valid clears after the transfer unless a new word completes on the same edge. data_out is stable while data_valid=1 and not transferred.
- Simultaneous completion and transfer: the new word loads, data_valid stays 1, no overrun.
- Completion while data_valid=1 and data_ready=0: the new word is dropped, data_out is unchanged, and overrun is set. The shifter still resets to IDLE.
- sync=1: bit_count -> 0 and partial bits are discarded, without affecting data_out or data_valid.
  - If ser_valid=1 on the same edge, that bit is bit 0 of a new word (state SHIFT, bit_count=1, direction latched).
  - Otherwise state -> IDLE.
  - For N bits in a row with sync asserted on the last one, that last bit starts a new word and no word completes.
- overrun: sticky until clr_overrun=1. If a set event and clr_overrun coincide, set wins (overrun=1).
- ser_valid=0: no state change except the handshake and sync effects.
- No combinational path from any input to any output; all outputs registered.

Test Plan:
- Reset: drive rst_n=0 asynchronously mid-word (bit_count=5) -> all outputs 0 immediately; after release, 8 bits 1,0,1,0,0,1,0,1 with msb_first=1 -> data_out=0xA5, data_valid=1.
- Direction: bits 0,0,0,1,1,1,1,0 with msb_first=1 -> 0x1E. Same sequence with msb_first=0 -> 0x78. Toggling msb_first after bit 3 -> result unchanged.
- Handshake/back-to-back: stream 0x3C then 0xC5 MSB-first continuously. Hold data_ready=1 only on the edge the second word completes -> data_valid stays 1, data_out goes 0x3C->0xC5, overrun=0.
- Overrun: data_ready=0, send 0x11 then 0x22 -> data_out stays 0x11, overrun=1. Pulse clr_overrun -> overrun=0. Assert clr_overrun on the edge a third word is dropped -> overrun=1.
- Resync: send 3 bits, pulse sync alone -> bit_count=0, busy=0, data_valid unchanged. Then sync with ser_valid=1, ser_in=1, plus 7 more bits 0 (msb_first=1) -> data_out=0x80.
- Gaps: 8 bits of 0xF0 MSB-first with random ser_valid idle cycles between bits -> single completion, data_out=0xF0; bit_count tracks 1..7 and never exceeds N-1.

Source files
------------

// File: rtl/serial_deserializer_if.sv
// Bundle between a serial bit source / word consumer and serial_deserializer.
//   ser_in, ser_valid, msb_first, sync, clr_overrun : serial side controls (to deserializer)
//   data_ready                                      : consumer accept (to deserializer)
//   data_out, data_valid, overrun, busy, bit_count  : deserializer status/outputs
// master = source/consumer side, slave = deserializer side.
interface serial_deserializer_if #(
   parameter int unsigned N = 8
);
   localparam int unsigned CW = $clog2(N);

   logic          ser_in;
   logic          ser_valid;
   logic          msb_first;
   logic          sync;
   logic          clr_overrun;
   logic [N-1:0]  data_out;
   logic          data_valid;
   logic          data_ready;
   logic          overrun;
   logic          busy;
   logic [CW-1:0] bit_count;

   modport master (
      output ser_in, ser_valid, msb_first, sync, clr_overrun, data_ready,
      input  data_out, data_valid, overrun, busy, bit_count
   );

   modport slave (
      input  ser_in, ser_valid, msb_first, sync, clr_overrun, data_ready,
      output data_out, data_valid, overrun, busy, bit_count
   );
endinterface

// File: rtl/serial_deserializer.sv
// Serial-to-parallel receiver: collects one bit per ser_valid strobe into N-bit words
// (MSB-first or LSB-first, latched per word), presents each finished word through a
// one-word valid/ready holding register, supports frame resync and flags dropped
// words with a sticky overrun bit.
// Ports:
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : serial_deserializer_if.slave (serial input, word output, status)
module serial_deserializer #(
   parameter int unsigned N = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   serial_deserializer_if.slave  bus
);
   localparam int unsigned CW = $clog2(N);

   typedef enum logic {StIdle, StShift} state_e;

   state_e        state_q, state_d;
   logic [N-1:0]  sh_q, sh_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          dir_q, dir_d;      // 1: shift left (MSB-first)
   logic [N-1:0]  dout_q, dout_d;
   logic          valid_q, valid_d;
   logic          ovr_q, ovr_d;

   logic          fresh;             // accepted bit starts a new word
   logic          dir_eff;
   logic [N-1:0]  base;
   logic [N-1:0]  sh_new;
   logic          complete;
   logic          ovr_set;

   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      dout_d  = dout_q;
      valid_d = valid_q;
      ovr_set = 1'b0;

      // A resync discards the partial word, so a bit on the same edge begins afresh.
      fresh   = (state_q == StIdle) || bus.sync;
      dir_eff = fresh ? bus.msb_first : dir_q;
      base    = fresh ? '0 : sh_q;
      sh_new  = dir_eff ? {base[N-2:0], bus.ser_in} : {bus.ser_in, base[N-1:1]};
      complete = bus.ser_valid && !fresh && (cnt_q == CW'(N - 1));

      if (valid_q && bus.data_ready) begin
         valid_d = 1'b0;
      end

      if (bus.sync) begin
         state_d = StIdle;
         cnt_d   = '0;
         sh_d    = '0;
      end

      if (bus.ser_valid) begin
         if (complete) begin
            state_d = StIdle;
            cnt_d   = '0;
            sh_d    = '0;
            // Holding register is free if empty or being drained on this edge.
            if (!valid_q || bus.data_ready) begin
               dout_d  = sh_new;
               valid_d = 1'b1;
            end else begin
               ovr_set = 1'b1;
            end
         end else begin
            state_d = StShift;
            cnt_d   = fresh ? CW'(1) : cnt_q + CW'(1);
            sh_d    = sh_new;
            dir_d   = dir_eff;
         end
      end

      // Set beats clear when both happen on one edge.
      if (ovr_set) begin
         ovr_d = 1'b1;
      end else if (bus.clr_overrun) begin
         ovr_d = 1'b0;
      end else begin
         ovr_d = ovr_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         sh_q    <= '0;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
         dout_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   assign bus.data_out   = dout_q;
   assign bus.data_valid = valid_q;
   assign bus.overrun    = ovr_q;
   assign bus.busy       = (state_q == StShift);
   assign bus.bit_count  = cnt_q;
endmodule
